// File: rtl/sram.sv
// sram: single-port synchronous RAM; write on wren only, read on rden only, both together ignored.
module sram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wren,
  input  logic             rden,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);
  localparam logic [AW:0] MAX_ADDR = DEPTH;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_in_range;
  logic             w_wr;
  logic             w_rd;
  assign w_in_range = {1'b0, addr} < MAX_ADDR;
  assign w_wr       = !rst && wren && !rden && w_in_range;
  assign w_rd       = rden && !wren;
  // Array kept free of reset so it can map onto a RAM macro; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[addr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (w_rd) rd_data <= w_in_range ? r_mem[addr] : '0;
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (!$isunknown({wren, rden, addr})) else $error("sram: X on control/address");
    if (!rst && wren && rden) $warning("sram: wren and rden both high, access ignored");
  end
`endif
endmodule

// File: tb/tb_sram.sv
// tb_sram: directed checks of reset, fill, readback, conflict, back-to-back and mid-sequence reset.
module tb_sram;
  logic        clk = 1'b0;
  logic        rst;
  logic        wren;
  logic        rden;
  logic [9:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  int checks = 0;
  int errors = 0;
  logic [31:0] vals [15] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9,
                             32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15};

  sram #(.WIDTH(32), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .wren(wren), .rden(rden),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic w, input logic rd, input logic [9:0] a, input logic [31:0] d);
    rst = r; wren = w; rden = rd; addr = a; wr_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp);
    checks++;
    assert (rd_data === exp) else begin
      errors++;
      $error("FAIL %s rd_data=%h expected=%h", tag, rd_data, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; rden = 1'b1; addr = '0; wr_data = '0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 10'h0, 32'h0);
      chk("reset", 32'h0);
    end
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 10'(i), vals[i]);
      chk("fill_hold", 32'h0);
    end
    step(0, 1, 0, 10'h3FF, 32'hAA);
    chk("fill_top_hold", 32'h0);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 1, 10'(i), 32'h0);
      chk("readback", vals[i]);
    end
    step(0, 0, 1, 10'h3FF, 32'h0);
    chk("readback_top", 32'hAA);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 1, 10'(i), 32'h0);
      chk("conflict_hold", 32'hAA);
    end
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 10'(i), 32'h0);
      chk("conflict_intact", vals[i]);
    end
    step(0, 1, 0, 10'h5, 32'hDEADBEEF);
    chk("b2b_write_hold", 32'h7);
    step(0, 0, 1, 10'h5, 32'h0);
    chk("b2b_read", 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 10'h0, 32'h0);
      chk("idle_hold", 32'hDEADBEEF);
    end
    step(1, 0, 1, 10'h2, 32'h0);
    chk("mid_reset", 32'h0);
    step(1, 1, 0, 10'h3, 32'h55);
    chk("reset_write_dropped", 32'h0);
    step(0, 0, 1, 10'h3, 32'h0);
    chk("after_reset_read", 32'h4);
    step(0, 0, 0, 10'h0, 32'h0);
    chk("after_reset_hold", 32'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
